mig_tt_sweeper: RTL

- Sequential truth-table extractor for the 7-input majority-function classification flow.
- Drives every minterm into an external combinational or pipelined function under test (FUT), samples its 1-bit output and assembles the full 2^N_IN-bit truth table.
- Streams the table out MSB-first in OUT_W-bit beats over a valid/ready interface, in the same hex-string order the classification set uses for function names.

---
 rtl/mig_tt_sweeper_pkg.sv | 19 +
 rtl/mig_tt_sweeper_if.sv | 12 +
 rtl/mig_tt_lat_pipe.sv | 41 ++++
 rtl/mig_tt_sweeper.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mig_tt_sweeper_pkg.sv
// rtl/mig_tt_sweeper_pkg.sv - shared FSM state type and table-size helpers for the truth-table sweeper
package mig_tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        DRAIN  = 2'd2,
        STREAM = 2'd3
    } tt_state_e;

    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

    function automatic int beats(input int n, input int w);
        return tt_w(n) / w;
    endfunction

endpackage

// File: rtl/mig_tt_sweeper_if.sv
// rtl/mig_tt_sweeper_if.sv - truth-table beat stream (data/valid/ready/last) with master and slave views
interface mig_tt_sweeper_if #(
    parameter int OUT_W = 32
);
    logic [OUT_W-1:0] tt_data;
    logic             tt_valid;
    logic             tt_ready;
    logic             tt_last;

    modport master (output tt_data, output tt_valid, output tt_last, input tt_ready);
    modport slave  (input tt_data, input tt_valid, input tt_last, output tt_ready);
endinterface

// File: rtl/mig_tt_lat_pipe.sv
// rtl/mig_tt_lat_pipe.sv - DEPTH-stage index/valid delay line matching the FUT response latency
module mig_tt_lat_pipe #(
    parameter int DEPTH = 0,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_idx,
    input  logic         in_vld,
    output logic [W-1:0] out_idx,
    output logic         out_vld
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_idx = in_idx;
            assign out_vld = in_vld;
        end else begin : g_pipe
            logic [W-1:0]     idx_q [DEPTH];
            logic [DEPTH-1:0] vld_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
                end else begin
                    idx_q[0] <= in_idx;
                    vld_q[0] <= in_vld;
                    for (int i = 1; i < DEPTH; i++) begin
                        idx_q[i] <= idx_q[i-1];
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            assign out_idx = idx_q[DEPTH-1];
            assign out_vld = vld_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/mig_tt_sweeper.sv
// rtl/mig_tt_sweeper.sv - sweeps all minterms through a FUT and streams its truth table MSB-first
// Optional MIG_TT_POPCOUNT_EN adds tt_ones / tt_balanced outputs.
module mig_tt_sweeper
    import mig_tt_pkg::*;
#(
    parameter int N_IN       = 7,
    parameter int OUT_W      = 32,
    parameter int SAMPLE_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [N_IN-1:0]   fn_in,
    input  logic              fn_out,
    mig_tt_sweeper_if.master  tt,
`ifdef MIG_TT_POPCOUNT_EN
    output logic [N_IN:0]     tt_ones,
    output logic              tt_balanced,
`endif
    output logic              done
);
    localparam int TT_W   = tt_w(N_IN);
    localparam int NBEATS = beats(N_IN, OUT_W);
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [N_IN:0]   LAST_CNT = (N_IN+1)'(TT_W - 1);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

    tt_state_e       state;
    logic [N_IN:0]   cnt;
    logic [TT_W-1:0] tbl;
    logic [BW-1:0]   beat;
    logic            valid_q;
    logic            last_q;
    logic [N_IN-1:0] p_idx;
    logic            p_vld;
    logic            last_sample;

    mig_tt_lat_pipe #(.DEPTH(SAMPLE_LAT), .W(N_IN)) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_idx  (fn_in),
        .in_vld  (state == SWEEP),
        .out_idx (p_idx),
        .out_vld (p_vld)
    );

    assign last_sample = p_vld && (p_idx == LAST_IDX);

    // The table shifts left after each accepted beat, so the top chunk is always the current beat.
    assign tt.tt_data  = valid_q ? tbl[TT_W-1 -: OUT_W] : '0;
    assign tt.tt_valid = valid_q;
    assign tt.tt_last  = last_q;

`ifdef MIG_TT_POPCOUNT_EN
    assign tt_balanced = (tt_ones == (N_IN+1)'(TT_W / 2));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            fn_in   <= '0;
            cnt     <= '0;
            tbl     <= '0;
            beat    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done    <= 1'b0;
`ifdef MIG_TT_POPCOUNT_EN
            tt_ones <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SWEEP;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        fn_in <= '0;
                        tbl   <= '0;
                        beat  <= '0;
`ifdef MIG_TT_POPCOUNT_EN
                        tt_ones <= '0;
`endif
                    end
                end
                SWEEP, DRAIN: begin
                    if (p_vld) begin
                        tbl[p_idx] <= fn_out;
`ifdef MIG_TT_POPCOUNT_EN
                        tt_ones <= tt_ones + (N_IN+1)'(fn_out);
`endif
                    end
                    if (state == SWEEP) begin
                        if (cnt != LAST_CNT) begin
                            cnt   <= cnt + 1'b1;
                            fn_in <= N_IN'(cnt + 1'b1);
                        end else begin
                            state <= DRAIN;
                        end
                    end
                    // With zero latency this fires in SWEEP and overrides the DRAIN step.
                    if (last_sample) begin
                        state   <= STREAM;
                        valid_q <= 1'b1;
                        last_q  <= (NBEATS == 1);
                    end
                end
                STREAM: begin
                    if (tt.tt_ready) begin
                        if (last_q) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done    <= 1'b1;
                            fn_in   <= '0;
                            cnt     <= '0;
                        end else begin
                            tbl    <= tbl << OUT_W;
                            beat   <= beat + 1'b1;
                            last_q <= (beat == BW'(NBEATS - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
